// File: rtl/fb_pkg.sv
// fb_pkg: shared types and default geometry for the framebuffer pixel write stage.
package fb_pkg;
   localparam int CORDW_D = 10;
   localparam int COLRW_D = 4;
   localparam int ADDRW_D = 17;
   localparam int H_RES_D = 320;
   localparam int V_RES_D = 240;
   typedef logic [CORDW_D-1:0] coord_t;
   typedef logic [COLRW_D-1:0] colr_t;
   typedef logic [ADDRW_D-1:0] fb_addr_t;
   typedef struct packed {
      fb_addr_t addr;
      colr_t    colr;
   } fb_pixel_t;
endpackage

// File: rtl/fb_pixel_fifo.sv
// fb_pixel_fifo: DEPTH-entry synchronous FIFO of fb_pixel_t with async active-low reset and occupancy count.
module fb_pixel_fifo
   import fb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  fb_pixel_t                din,
   input  logic                     pop,
   output fb_pixel_t                dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   fb_pixel_t mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   // Extra pointer MSB separates full from empty when the index bits match.
   always_comb begin
      empty   = wr_ptr == rd_ptr;
      full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      count   = wr_ptr - rd_ptr;
      do_push = push && !full;
      do_pop  = pop && !empty;
      dout    = mem[rd_ptr[AW-1:0]];
   end
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      end
endmodule

// File: rtl/fb_pixel_write.sv
// fb_pixel_write: turns drawer pixels into linear framebuffer writes through S1 and a FIFO, back-pressuring via oe.
// Define FB_PIXEL_CLIP_EN to drop off-screen pixels and expose the saturating clip_cnt counter.
module fb_pixel_write
   import fb_pkg::*;
#(
   parameter int CORDW = CORDW_D,
   parameter int COLRW = COLRW_D,
   parameter int H_RES = H_RES_D,
   parameter int V_RES = V_RES_D,
   parameter int ADDRW = ADDRW_D,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             drawing,
   input  logic [CORDW-1:0] x,
   input  logic [CORDW-1:0] y,
   input  logic [COLRW-1:0] colr,
   output logic             oe,
   output logic             fb_we,
   output logic [ADDRW-1:0] fb_addr,
   output logic [COLRW-1:0] fb_colr,
   input  logic             fb_ready,
   output logic             busy
`ifdef FB_PIXEL_CLIP_EN
   ,
   output logic [15:0]      clip_cnt
`endif
);
   localparam int AW = $clog2(DEPTH);
   logic run, s1_valid, in_range, accept, empty, full;
   logic [AW:0] count;
   logic [ADDRW-1:0] addr;
   fb_pixel_t s1_pix, head;
   always_comb begin
      addr = ADDRW'(y) * ADDRW'(H_RES) + ADDRW'(x);
`ifdef FB_PIXEL_CLIP_EN
      in_range = (32'(x) < H_RES) && (32'(y) < V_RES);
`else
      in_range = 1'b1;
`endif
      accept  = drawing && in_range;
      // run holds oe low through reset and releases it on the first edge after.
      oe      = run && !full && ((32'(count) + 32'(s1_valid)) < DEPTH);
      fb_we   = !empty;
      fb_addr = ADDRW'(head.addr);
      fb_colr = COLRW'(head.colr);
      busy    = s1_valid || (count != '0);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         run      <= 1'b0;
         s1_valid <= 1'b0;
         s1_pix   <= '0;
      end else begin
         run      <= 1'b1;
         s1_valid <= accept;
         if (accept) s1_pix <= '{addr: fb_addr_t'(addr), colr: colr_t'(colr)};
      end
`ifdef FB_PIXEL_CLIP_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) clip_cnt <= '0;
      else if (drawing && !in_range && clip_cnt != 16'hFFFF) clip_cnt <= clip_cnt + 16'd1;
`endif
   fb_pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (s1_valid),
      .din   (s1_pix),
      .pop   (fb_we && fb_ready),
      .dout  (head),
      .empty (empty),
      .full  (full),
      .count (count)
   );
endmodule

// File: doc/fb_pixel_write.md
# fb_pixel_write

Framebuffer write stage directly downstream of the line drawer. Consumes the drawer's pixel stream (`drawing`, `x`, `y`) and a colour. Converts each pixel to a linear framebuffer address and queues it in a small FIFO toward the framebuffer write port. Back-pressures the drawer through `oe`, so no pixel is ever lost or duplicated.

## Interface
Parameters:
- `CORDW`, 10: coordinate width in bits
- `COLRW`, 4: colour width in bits
- `H_RES`, 320: framebuffer width in pixels
- `V_RES`, 240: framebuffer height in pixels
- `ADDRW`, 17: framebuffer address width; must satisfy H_RES*V_RES <= 2^ADDRW
- `DEPTH`, 4: FIFO entries; power of two, >= 2

Ports (one clock; reset is asynchronous and active-low):
- `clk` in, 1: clock
- `rst_n` in, 1: asynchronous active-low reset
- `drawing` in, 1: pixel valid from drawer; already qualified by `oe`
- `x` in, CORDW: pixel horizontal position
- `y` in, CORDW: pixel vertical position
- `colr` in, COLRW: pixel colour; sampled with `x`/`y`
- `oe` out, 1: accept enable, fed to the drawer's output enable
- `fb_we` out, 1: write request; high whenever the FIFO is non-empty
- `fb_addr` out, ADDRW: write address (FIFO head)
- `fb_colr` out, COLRW: write data (FIFO head)
- `fb_ready` in, 1: framebuffer accepts the write this cycle
- `busy` out, 1: stage or FIFO holds a pixel
- `clip_cnt` out, 16: clipped-pixel count; present only with `FB_PIXEL_CLIP_EN`

## Operation
- **Accept:** a pixel is accepted in any cycle where `drawing`=1. Because `drawing` is already qualified by `oe`, the drawer has advanced its position by the next edge.
- **S1 register:** on accept, S1 captures `colr` and `addr = y*H_RES + x`, computed in ADDRW bits (constant multiply, shift-add permitted), and sets `s1_valid`.
- **FIFO push:** S1 pushes into the FIFO on the following edge when `s1_valid`=1.
- **Pop:** occurs when `fb_we && fb_ready`. The FIFO head drives `fb_addr`/`fb_colr` directly.
- **Accept enable:** `oe = (count + s1_valid) < DEPTH`, decoded from registers only (no combinational path from `drawing` or `fb_ready`). This guarantees the FIFO never overflows.
- **Simultaneous events:** a push and a pop in the same cycle leave `count` unchanged. A push into a full FIFO cannot occur by construction; the bench asserts this.
- **Pointers:** log2(DEPTH)+1 bits each; full/empty come from the pointer MSB comparison; both wrap naturally.
- **busy:** `busy = s1_valid || (count != 0)`.
- **Ordering:** pixel order is preserved exactly.

## Timing
- **Reset (rst_n low):** `s1_valid`=0, FIFO empty, `fb_we`=0, `busy`=0, `oe`=0, `clip_cnt`=0. All take effect immediately (asynchronous).
- **After reset release:** `oe`=1 from the first cycle after `rst_n` rises.
- **Latency:** a pixel accepted in cycle N appears on `fb_we`/`fb_addr` in cycle N+2 (S1 at N+1, FIFO at N+2).
- **Throughput:** one pixel per cycle sustained while `fb_ready`=1.
- **Back-pressure:** with `fb_ready`=0, at most DEPTH pixels are accepted, then `oe` drops. `oe` rises in the cycle after the first pop frees space.
- **Reset mid-line:** queued and in-flight pixels are discarded, and `fb_we` deasserts asynchronously. Restarting the drawer is the controller's responsibility.

## Configuration
- **`FB_PIXEL_CLIP_EN` defined:**
  - Pixels with `x >= H_RES` or `y >= V_RES` are accepted (consuming the `oe` slot) but never loaded into S1.
  - `clip_cnt` increments per clipped pixel and saturates at 16'hFFFF.
- **Undefined:**
  - No bounds check; out-of-range addresses wrap modulo 2^ADDRW.
  - `clip_cnt` port and counter are absent.

## Structure
- **Package `fb_pkg`:** coordinate, colour and address typedefs (`coord_t`, `colr_t`, `fb_addr_t`), the default H_RES/V_RES constants, and a `fb_pixel_t` struct {addr, colr} used as the FIFO word.
- **Sub-module `fb_pixel_fifo`:** a parameterised DEPTH x `fb_pixel_t` synchronous FIFO with async active-low reset, exposing `count`. S1, the address computation and the clip logic stay in the top.

## Test plan
- **Address and latency:** single pixel x=5, y=2, colr=4'hA with `fb_ready`=1 -> `fb_we`=1 for one cycle at N+2, `fb_addr`=645, `fb_colr`=4'hA; then `busy`=0.
- **Throughput:** 10-pixel burst with `fb_ready`=1 -> 10 writes in order on consecutive cycles; `oe` never drops.
- **Back-pressure:** `fb_ready`=0 with `drawing` held high -> exactly 4 pixels accepted, then `oe`=0; release `fb_ready` -> `oe` returns after the first pop, all pixels written in order, none lost.
- **Wrap-around:** 3*DEPTH+1 pixels with `fb_ready` toggling every cycle -> write sequence matches the input sequence across pointer wrap.
- **Reset mid-operation:** `rst_n` pulsed low with 3 pixels queued -> `fb_we`=0 immediately, no further writes after release, `oe`=1 one cycle after release.
- **Clipping (`FB_PIXEL_CLIP_EN`):** pixels (319,239), (320,0), (0,240) -> one write at addr 76799; `clip_cnt`=2.
